// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and sizes for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int INST_W     = 32;
    localparam int PC_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fifo2
// Description : Two-entry {pc, inst} buffer with flush; head shown combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fifo2
    import ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [INST_W-1:0] push_inst,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic [1:0]        count
);

    localparam logic [1:0] c_full = 2'(FIFO_DEPTH);

    fetch_entry_t r_mem [FIFO_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_pop;
    logic         w_do_push;

    // Pop on empty is dropped; a push into a full buffer needs a same-cycle pop.
    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != c_full) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= '{pc: push_pc, inst: push_inst};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_pc   = r_mem[r_rd_ptr].pc;
    assign head_inst = r_mem[r_rd_ptr].inst;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : Sequential instruction fetch from a small ROM into a 2-deep buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ROM_BYTES = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};
    localparam logic [1:0]  c_full     = 2'(FIFO_DEPTH);

    ifu_state_t  r_state;
    logic [31:0] r_pc;
    logic        r_halted;
    logic [1:0]  w_count;
    logic        w_redirect;
    logic        w_pop;
    logic        w_in_rom;
    logic        w_push;
    logic [31:0] w_next_pc;
    logic        w_unused_lsbs;

    assign w_unused_lsbs = ^redirect_pc[1:0];

    assign w_redirect = redirect_valid && (r_state != IDLE);
    assign w_pop      = out_valid && out_ready;
    assign w_in_rom   = r_pc < ROM_BYTES;
    assign w_next_pc  = r_pc + 32'd4;
    assign w_push     = (r_state == RUN) && !w_redirect && w_in_rom &&
                        ((w_count != c_full) || w_pop);

    // Redirect outranks every state transition except reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= c_reset_pc;
            r_halted <= 1'b0;
        end else if (w_redirect) begin
            r_state  <= RUN;
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (!w_in_rom) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_push) begin
                        r_pc <= w_next_pc;
                        if (w_next_pc >= ROM_BYTES) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state  <= IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    ifu_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (w_redirect),
        .push_pc   (r_pc),
        .push_inst (rom_inst),
        .head_pc   (out_pc),
        .head_inst (out_inst),
        .count     (w_count)
    );

    assign rom_addr  = {r_pc[31:2], 2'b00};
    assign out_valid = (w_count != 2'd0);
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_ctrl
// Description : Vector table plus scoreboard bench for inst_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam logic [31:0] c_r1 = 32'h3c02_5678;
    localparam logic [31:0] c_r2 = 32'h3c01_1234;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        halted;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;
        logic        exp_halted;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    function automatic logic [31:0] rom_word(input logic [4:0] idx);
        case (idx)
            5'd0:    return 32'h0000_0000;
            5'd1:    return c_r1;
            5'd2:    return c_r2;
            default: return 32'hA500_0000 + {27'd0, idx};
        endcase
    endfunction

    assign rom_inst = rom_word(rom_addr[6:2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc,
                       input logic ev, input logic cd, input logic [31:0] epc,
                       input logic [31:0] einst, input logic [31:0] eaddr, input logic eh);
        vec_t v;
        v = '{r, rdy, redir, rpc, ev, cd, epc, einst, eaddr, eh};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc);
        rst_n          = r;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    // Drains the scoreboard with the current ready policy; random stalls when rnd is set.
    task automatic run_sb(input string tag, input int budget, input bit rnd, input bit until_halt,
                          output logic [31:0] last_pc);
        int cyc;
        exp_t e;
        last_pc = 32'hFFFF_FFFF;
        cyc = 0;
        while (cyc < budget && !(sb_q.size() == 0 && (!until_halt || (halted && !out_valid)))) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk({tag, " extra delivery pc"}, out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, " pc"}, out_pc, e.pc);
                    chk({tag, " inst"}, out_inst, e.inst);
                    last_pc = out_pc;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " pending entries"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        logic [31:0] last_pc;
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset values, first fetch latency
        add(0,1,0,32'h0,  0,1,32'h0, 32'h0,32'h0, 0);
        add(1,1,0,32'h0,  0,0,32'h0, 32'h0,32'h0, 0);
        add(1,1,0,32'h0,  1,1,32'h0, 32'h0,32'h4, 0);
        add(1,1,0,32'h0,  1,1,32'h4, c_r1, 32'h8, 0);
        // Backpressure fills the buffer, then back-to-back delivery
        add(0,0,0,32'h0,  0,1,32'h0, 32'h0,32'h0, 0);
        add(1,0,0,32'h0,  0,0,32'h0, 32'h0,32'h0, 0);
        add(1,0,0,32'h0,  1,1,32'h0, 32'h0,32'h4, 0);
        add(1,0,0,32'h0,  1,1,32'h0, 32'h0,32'h8, 0);
        add(1,0,0,32'h0,  1,1,32'h0, 32'h0,32'h8, 0);
        add(1,0,0,32'h0,  1,1,32'h0, 32'h0,32'h8, 0);
        add(1,1,0,32'h0,  1,1,32'h4, c_r1, 32'hC, 0);
        add(1,1,0,32'h0,  1,1,32'h8, c_r2, 32'h10,0);
        add(1,1,0,32'h0,  1,1,32'hC, 32'hA500_0003,32'h14,0);
        // Misaligned redirect while full
        add(1,0,1,32'h6,  0,0,32'h0, 32'h0,32'h4, 0);
        add(1,0,0,32'h0,  1,1,32'h4, c_r1, 32'h8, 0);
        add(1,0,0,32'h0,  1,1,32'h4, c_r1, 32'hC, 0);
        // Pop and redirect together: 0x8 must never surface
        add(1,1,1,32'h10, 0,0,32'h0, 32'h0,32'h10,0);
        add(1,1,0,32'h0,  1,1,32'h10,32'hA500_0004,32'h14,0);
        add(1,1,0,32'h0,  1,1,32'h14,32'hA500_0005,32'h18,0);
        add(1,0,0,32'h0,  1,1,32'h14,32'hA500_0005,32'h1C,0);
        // Mid-stream reset with two buffered entries; redirect in IDLE ignored
        add(0,0,0,32'h0,  0,1,32'h0, 32'h0,32'h0, 0);
        add(1,1,1,32'h40, 0,0,32'h0, 32'h0,32'h0, 0);
        add(1,1,0,32'h0,  1,1,32'h0, 32'h0,32'h4, 0);
        add(1,1,0,32'h0,  1,1,32'h4, c_r1, 32'h8, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d out_inst", i), out_inst, vecs[i].exp_inst);
            end
        end

        // Free run over the whole ROM with random stalls
        drive(0, 1, 0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sb_q.push_back('{pc: 32'(i * 4), inst: rom_word(5'(i))});
        end
        run_sb("freerun", 600, 1'b1, 1'b1, last_pc);
        chk("freerun last pc", last_pc, 32'h7C);
        chk("freerun halted", {31'd0, halted}, 32'd1);
        chk("freerun drained", {31'd0, out_valid}, 32'd0);

        // Redirect out of HALT
        drive(1, 1, 1, 32'h8);
        redirect_valid = 1'b0;
        chk("unhalt halted", {31'd0, halted}, 32'd0);
        chk("unhalt out_valid", {31'd0, out_valid}, 32'd0);
        sb_q.push_back('{pc: 32'h8, inst: c_r2});
        sb_q.push_back('{pc: 32'hC, inst: 32'hA500_0003});
        run_sb("unhalt", 20, 1'b0, 1'b0, last_pc);

        // Redirect beyond the ROM: RUN for one cycle, then HALT with nothing fetched
        drive(1, 1, 1, 32'h100);
        chk("oob halted early", {31'd0, halted}, 32'd0);
        chk("oob rom_addr", rom_addr, 32'h100);
        drive(1, 1, 0, 32'h0);
        chk("oob halted", {31'd0, halted}, 32'd1);
        chk("oob out_valid", {31'd0, out_valid}, 32'd0);
        drive(1, 1, 0, 32'h0);
        chk("oob stays empty", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
